// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
//   state_t     : 2-bit FSM state encoding (also driven on the top-level `state` port)
//   STATE_W     : width of state_t
//   timer_width : width of the shared state timer, sized from the cycle parameters
package pll_lock_supervisor_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StResetPll = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } state_t;

    // Enough bits to hold (largest cycle count - 1); never narrower than 1 bit.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset to 0.
// Ports:
//   clk     : destination clock
//   sresetn : synchronous active-low reset
//   d       : asynchronous input bit
//   q       : input bit re-timed to clk, DEPTH edges later
module sync_bit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic sresetn,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor running on the PLL reference clock. Sequences PLL reset, waits for
// lock with timeout/retry, qualifies lock stability and then asserts `ready`.
// Ports:
//   clk         : PLL reference clock (board oscillator)
//   sresetn     : synchronous active-low reset
//   pll_locked  : PLL lock flag, asynchronous to clk
//   restart     : single-cycle request to re-run the whole sequence
//   pll_resetb  : PLL RESETB, 0 holds the PLL in reset
//   ready       : PLL output locked and qualified
//   state       : current FSM state (state_t encoding)
//   retry_count : saturating count of lock timeouts
//   loss_count  : saturating count of lock losses from RUN
// Build option: PLL_LOCK_SUPERVISOR_STATS_EN implements the two statistics counters;
// without it both count ports read 0 and no counter flops exist.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               sresetn,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_resetb,
    output logic               ready,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retry_count,
    output logic [CNT_W-1:0]   loss_count
);

    localparam int unsigned TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);

    logic               locked_s;
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pll_resetb_q, ready_q;

    sync_bit #(
        .DEPTH(SYNC_STAGES)
    ) u_sync_locked (
        .clk    (clk),
        .sresetn(sresetn),
        .d      (pll_locked),
        .q      (locked_s)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StResetPll: begin
                if (timer_q == RST_LAST) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s)                    state_d = StStable;
                else if (timer_q == LOCK_LAST)   state_d = StResetPll;
            end
            StStable: begin
                // A lock drop beats the terminal count in the same cycle.
                if (!locked_s)                   state_d = StWaitLock;
                else if (timer_q == STABLE_LAST) state_d = StRun;
            end
            StRun: begin
                if (!locked_s) state_d = StResetPll;
            end
            default: state_d = StResetPll;
        endcase
        if (restart) state_d = StResetPll;
        // restart counts as a fresh entry, so RESET_PLL re-arms its full hold time.
        timer_d = (restart || (state_d != state_q)) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q      <= StResetPll;
            timer_q      <= '0;
            pll_resetb_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pll_resetb_q <= (state_d != StResetPll);
            ready_q      <= (state_d == StRun);
        end
    end

    assign state      = state_q;
    assign pll_resetb = pll_resetb_q;
    assign ready      = ready_q;

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    logic             retry_evt, loss_evt;
    logic [CNT_W-1:0] retry_q, loss_q;

    // restart suppresses both events since it overrides the transition.
    assign retry_evt = !restart && (state_q == StWaitLock) && !locked_s &&
                       (timer_q == LOCK_LAST);
    assign loss_evt  = !restart && (state_q == StRun) && !locked_s;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            if (retry_evt && (retry_q != '1)) retry_q <= retry_q + 1'b1;
            if (loss_evt && (loss_q != '1))   loss_q  <= loss_q + 1'b1;
        end
    end

    assign retry_count = retry_q;
    assign loss_count  = loss_q;
`else
    assign retry_count = '0;
    assign loss_count  = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor.
module tb_pll_lock_supervisor;

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sresetn;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       ready;
    logic [1:0] state;
    logic [3:0] retry_count;
    logic [3:0] loss_count;

    int checks = 0;
    int errors = 0;
    int n;
    bit track_ready = 1'b0;
    bit ready_seen  = 1'b0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .SYNC_STAGES  (2),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .sresetn    (sresetn),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .ready      (ready),
        .state      (state),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always @(negedge clk) if (track_ready && ready) ready_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:       return {31'd0, pll_resetb};
            1:       return {31'd0, ready};
            default: return {30'd0, state};
        endcase
    endfunction

    // Count negedges until the probed output takes the value; bounded.
    task automatic edges_until(input string tag, input int sel, input logic [31:0] value,
                               output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (probe(sel) !== value && cnt < 200);
        check_eq({tag, " reached"}, probe(sel), value);
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
        if (!StatsEn) return 0;
        return (v > 15) ? 15 : v;
    endfunction

    initial begin
        sresetn    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst state", state, 0);
        check_eq("rst resetb", pll_resetb, 0);
        check_eq("rst ready", ready, 0);
        check_eq("rst retry", retry_count, 0);
        check_eq("rst loss", loss_count, 0);

        // Normal lock
        sresetn = 1'b1;
        edges_until("resetb rise", 0, 1, n);
        check_eq("resetb low cycles", n, 4);
        repeat (3) @(negedge clk);
        check_eq("wait_lock state", state, 1);
        pll_locked = 1'b1;
        edges_until("ready rise", 1, 1, n);
        check_eq("locked to ready edges", n, 11);
        check_eq("run state", state, 3);

        // Loss in RUN
        pll_locked = 1'b0;
        edges_until("ready fall", 1, 0, n);
        check_eq("loss to ready fall edges", n, 3);
        check_eq("loss resetb", pll_resetb, 0);
        check_eq("loss state", state, 0);
        check_eq("loss count", loss_count, exp_cnt(1));
        check_eq("loss retry", retry_count, 0);

        // Glitch in STABLE at count 5; the drop lands on the terminal count cycle
        pll_locked = 1'b1;
        edges_until("stable entry", 2, 2, n);
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        check_eq("glitch still stable", state, 2);
        @(negedge clk);
        check_eq("glitch back to wait", state, 1);
        edges_until("stable re-entry", 2, 2, n);
        check_eq("stable re-entry edges", n, 1);
        edges_until("ready after glitch", 1, 1, n);
        check_eq("stable recount edges", n, 8);
        check_eq("glitch retry", retry_count, 0);
        check_eq("glitch loss", loss_count, exp_cnt(1));

        // restart in RUN
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_eq("restart state", state, 0);
        check_eq("restart ready", ready, 0);
        check_eq("restart resetb", pll_resetb, 0);
        check_eq("restart loss", loss_count, exp_cnt(1));
        check_eq("restart retry", retry_count, 0);

        // sresetn during WAIT_LOCK
        pll_locked = 1'b0;
        edges_until("wait after restart", 2, 1, n);
        sresetn = 1'b0;
        @(negedge clk);
        check_eq("sreset state", state, 0);
        check_eq("sreset resetb", pll_resetb, 0);
        check_eq("sreset ready", ready, 0);
        check_eq("sreset retry", retry_count, 0);
        check_eq("sreset loss", loss_count, 0);

        // Never locks: 4 low + 20 high per attempt, retries saturate at 15
        sresetn     = 1'b1;
        track_ready = 1'b1;
        edges_until("first rise", 0, 1, n);
        check_eq("first low cycles", n, 4);
        for (int i = 1; i <= 17; i++) begin
            edges_until("retry fall", 0, 0, n);
            check_eq("wait_lock high cycles", n, 20);
            check_eq("retry count", retry_count, exp_cnt(i));
            edges_until("retry rise", 0, 1, n);
            check_eq("retry low cycles", n, 4);
        end
        track_ready = 1'b0;
        check_eq("ready stayed low", ready_seen, 0);
        check_eq("never-lock loss", loss_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the iCE40 PLL from the reference-clock side. It drives the PLL's active-low reset and consumes the PLL's asynchronous lock flag. It sequences PLL reset, lock wait with timeout and retry, and a lock-stability qualification, then asserts `ready` to release downstream reset logic. It sits between the board oscillator domain and the `SB_PLL40_CORE` wrapper. Because it runs on the input clock, it keeps working while the PLL output is absent.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_resetb` is held low per reset attempt; ≥1.
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before retry; ≥2.
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before `ready`; ≥1.
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked`; ≥2.
- `CNT_W`, 8: width of the statistics counters.

Ports:
- `clk` in 1: PLL reference clock (board oscillator).
- `sresetn` in 1: reset, synchronous, active-low.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `restart` in 1: single-cycle request to re-run the full sequence.
- `pll_resetb` out 1: to PLL RESETB; 0 holds the PLL in reset.
- `ready` out 1: PLL output is locked and qualified.
- `state` out 2: current FSM state.
- `retry_count` out CNT_W: lock timeouts since reset, saturating (stats only).
- `loss_count` out CNT_W: lock losses from RUN, saturating (stats only).

## Operation
- `pll_locked` passes through a chain of `SYNC_STAGES` flops to give `locked_s`. No other logic samples `pll_locked` directly.
- One shared timer is used by all states. It clears on every state entry and increments each cycle while in a state. The timer width is the clog2 of the largest of the three cycle parameters.
- FSM states, with encodings:
  - RESET_PLL = 0: `pll_resetb` = 0. Move to WAIT_LOCK when timer == RST_CYCLES-1.
  - WAIT_LOCK = 1: `pll_resetb` = 1.
    - If `locked_s` = 1, move to STABLE.
    - Else, if timer == LOCK_TIMEOUT-1, move to RESET_PLL and increment `retry_count`.
  - STABLE = 2:
    - If `locked_s` = 0, move to WAIT_LOCK with the timer cleared. This is a glitch, not a retry.
    - Else, if timer == STABLE_CYCLES-1, move to RUN.
  - RUN = 3: `ready` = 1. If `locked_s` = 0, move to RESET_PLL and increment `loss_count`.
- `restart` = 1 in any state forces RESET_PLL on the next edge. It takes priority over every other transition and does not touch the counters. `restart` in RESET_PLL restarts the reset hold timer.
- `pll_resetb` and `ready` are registered decodes of the next state, so they change on the same edge as `state`.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: `state` = RESET_PLL, `pll_resetb` = 0, `ready` = 0, timer = 0, `retry_count` = 0, `loss_count` = 0.
- `sresetn` low mid-sequence returns all of these values on the next edge, regardless of state.
- `pll_resetb` low pulse lasts exactly RST_CYCLES cycles per attempt.
- Delay from a `pll_locked` edge to its effect on `locked_s` is SYNC_STAGES edges.
- Minimum delay from `locked_s` rising in WAIT_LOCK to `ready` = 1 is STABLE_CYCLES+1 edges.
- `ready` falls 1 edge after `locked_s` falls in RUN. From the raw pin, that is SYNC_STAGES+1 edges.
- `locked_s` low and a timer terminal count in the same cycle of STABLE: the lock drop wins.

## Configuration
- Macro `PLL_LOCK_SUPERVISOR_STATS_EN`.
- When defined, `retry_count` and `loss_count` are implemented as described above.
- When undefined, both ports are tied to 0, no counter flops exist, and FSM behaviour is unchanged.

## Structure
- Shared package `pll_lock_supervisor_pkg` holds:
  - the `state_t` enum (2-bit, encodings as above);
  - a `STATE_W` constant;
  - a `clog2`-based helper for the timer width.
- One sub-module, `sync_bit`: a parameterized-depth single-bit synchronizer with synchronous active-low reset to 0. It is reusable elsewhere in the codebase.
- The FSM, timer and counters stay in the top module.

## Test plan
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYNC_STAGES=2, CNT_W=4.

- Normal lock: release reset, then raise `pll_locked` 3 cycles after `pll_resetb` rises.
  - `pll_resetb` is low for exactly 4 cycles.
  - `ready` rises 2+8+1 edges after `pll_locked` rises.
- Never locks: hold `pll_locked` = 0.
  - `pll_resetb` pulses low for 4 cycles every 24 cycles.
  - `retry_count` counts 1, 2, 3 and saturates at 15.
  - `ready` stays 0.
- Glitch during STABLE: drop `pll_locked` for 1 cycle at stable count 5.
  - FSM returns to WAIT_LOCK, then STABLE restarts its 8-cycle count.
  - `retry_count` and `loss_count` are unchanged.
- Loss in RUN: drop `pll_locked` while `ready` = 1.
  - `ready` is 0 three edges later.
  - `pll_resetb` = 0 and `loss_count` = 1.
- `restart` and `sresetn`:
  - `restart` pulse in RUN: `state` = 0 and `ready` = 0 on the next edge; counters unchanged.
  - `sresetn` low during WAIT_LOCK: all outputs return to their reset values.
- Macro off: repeat the never-locks scenario; `retry_count` stays 0 throughout.
